// File: rtl/sixteen_way_arbiter_pkg.sv
// Shared types and constants for the sixteen-way round-robin arbiter.
// The round-robin search helper lives here so the top stays a plain FSM.
package sixteen_way_arbiter_pkg;

    localparam int NUM_REQ          = 16;
    localparam int ID_W             = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // First set bit at or after ptr+1, wrapping; ptr itself is checked last.
    // Walking from the far end lets the nearest hit overwrite earlier ones.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [ID_W-1:0]    ptr);
        pick_t           p;
        logic [ID_W-1:0] idx;
        p = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sixteen_way_arbiter_grant_decoder.sv
// One-hot grant decoder: 4-bit holder index plus enable to a 16-bit grant.
module grant_decoder
    import sixteen_way_arbiter_pkg::*;
(
    input  logic [ID_W-1:0]    id,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    assign onehot = en ? (NUM_REQ'(1) << id) : '0;

endmodule

// File: rtl/sixteen_way_arbiter.sv
// Sixteen-way round-robin arbiter with hold-until-release grants.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles and pulse timeout.
module sixteen_way_arbiter
    import sixteen_way_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rel,       // holder's release pulse (release is a reserved word)
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must lie in 2..255");
    end

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_REQ-1:0] search_req;
    pick_t              pick;
    logic               held;
    logic               forced;
    logic               end_grant;
    logic               new_grant;

    // The holder keeps the resource only while it still requests and has not released.
    assign held       = req[id_q] & ~rel;
    assign end_grant  = (state_q == GRANT) & (~held | forced);
    assign search_req = (state_q == GRANT) ? (req & ~(NUM_REQ'(1) << id_q)) : req;
    assign pick       = rr_pick(search_req, ptr_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d   = GRANT;
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (end_grant) begin
                    state_d   = pick.found ? GRANT : IDLE;
                    new_grant = pick.found;
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_grant) begin
            id_d  = pick.idx;
            ptr_d = pick.idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q;
    logic       timeout_q;

    // hold_q counts completed cycles of the current grant; the last allowed cycle forces hand-off.
    assign forced = (state_q == GRANT) & held & (hold_q == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= forced;
            if (new_grant) begin
                hold_q <= '0;
            end else if (state_q == GRANT) begin
                hold_q <= hold_q + 8'd1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gnt_id    = id_q;
    assign gnt_valid = (state_q == GRANT);

    grant_decoder u_grant_decoder (
        .id     (id_q),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_sixteen_way_arbiter.sv
// Scoreboard bench for sixteen_way_arbiter: a behavioural model predicts each cycle's outputs
// into a queue, and a monitor pops and compares after every rising edge.
module tb_sixteen_way_arbiter;

    localparam int TB_MAX_HOLD = 4;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    sixteen_way_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] gnt;
        int          id;
        logic        valid;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: who holds the resource, where the search last stopped,
    // and how many cycles the current holder has had it.
    logic m_valid;
    int   m_id;
    int   m_ptr;
    int   m_held;
    logic m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_search(input logic [15:0] r, input int after, input int excl);
        for (int k = 1; k <= 16; k++) begin
            int idx;
            idx = (after + k) % 16;
            if (idx != excl && r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_ptr   = 15;
        m_held  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_grant(input int w);
        m_valid = 1'b1;
        m_id    = w;
        m_ptr   = w;
        m_held  = 1;
    endfunction

    function automatic void model_edge(input logic [15:0] r, input logic rl);
        int   w;
        logic wants;
        logic forced;
        m_to = 1'b0;
        if (!m_valid) begin
            w = rr_search(r, m_ptr, -1);
            if (w >= 0) model_grant(w);
        end else begin
            wants  = r[m_id] && !rl;
            forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
            forced = wants && (m_held == TB_MAX_HOLD);
`endif
            if (!wants || forced) begin
                m_to = forced;
                w = rr_search(r, m_ptr, m_id);
                if (w >= 0) model_grant(w);
                else        m_valid = 1'b0;
            end else begin
                m_held++;
            end
        end
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.gnt   = m_valid ? (16'd1 << m_id) : 16'd0;
        e.id    = m_id;
        e.valid = m_valid;
        e.to    = m_to;
        exp_q.push_back(e);
    endfunction

    task automatic step(input logic [15:0] r, input logic rl);
        @(negedge clk);
        req = r;
        rel = rl;
        model_edge(r, rl);
        push_expect();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Asserts reset away from the clock edge, checks the asynchronous clear, holds it across one edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        #1;
        check("rst_async_gnt", 32'(gnt), 32'h0);
        check("rst_async_valid", 32'(gnt_valid), 32'h0);
        model_reset();
        push_expect();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_gnt", 32'(gnt), 32'(e.gnt));
                check("sb_valid", 32'(gnt_valid), 32'(e.valid));
                check("sb_timeout", 32'(timeout), 32'(e.to));
                if (e.valid) check("sb_gnt_id", 32'(gnt_id), 32'(e.id));
            end
        end
    end

    initial begin : stimulus
        logic [15:0] r;
        logic        rl;
        int          order[3];
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        model_reset();

        // Idle after reset with no requests.
        do_reset();
        repeat (5) step(16'h0000, 1'b0);
        settle();
        check("idle_valid", 32'(gnt_valid), 32'h0);
        check("idle_timeout", 32'(timeout), 32'h0);

        // Back-to-back hand-off with no gap, then back to idle.
        do_reset();
        step(16'h0081, 1'b0);
        settle();
        check("first_grant", 32'(gnt), 32'h0001);
        step(16'h0081, 1'b1);
        settle();
        check("handoff_no_gap", 32'(gnt), 32'h0080);
        step(16'h0080, 1'b1);
        settle();
        check("release_to_idle", 32'(gnt_valid), 32'h0);

        // Wrap-around between requesters 0 and 15.
        do_reset();
        step(16'h8001, 1'b0);
        settle();
        check("wrap_first", 32'(gnt_id), 32'd0);
        order = '{15, 0, 15};
        for (int i = 0; i < 3; i++) begin
            step(16'h8001, 1'b1);
            settle();
            check("wrap_order", 32'(gnt_id), 32'(order[i]));
        end

        // Holder drops its request; next requester takes over on the same edge.
        do_reset();
        step(16'h0008, 1'b0);
        step(16'h0008, 1'b0);
        step(16'h0030, 1'b0);
        settle();
        check("drop_gnt", 32'(gnt), 32'h0010);
        check("drop_gnt_id", 32'(gnt_id), 32'd4);

        // Reset mid-grant, then the same requester is granted again.
        do_reset();
        step(16'h0400, 1'b0);
        settle();
        check("pre_rst_grant", 32'(gnt), 32'h0400);
        do_reset();
        step(16'h0400, 1'b0);
        settle();
        check("post_rst_regrant", 32'(gnt), 32'h0400);

`ifdef ARB_TIMEOUT_EN
        // Forced revocation after TB_MAX_HOLD cycles.
        do_reset();
        for (int i = 0; i <= TB_MAX_HOLD; i++) begin
            step(16'h0006, 1'b0);
            settle();
            check("hold_gnt_id", 32'(gnt_id), (i < TB_MAX_HOLD) ? 32'd1 : 32'd2);
            check("hold_timeout", 32'(timeout), (i == TB_MAX_HOLD) ? 32'd1 : 32'd0);
        end
`endif

        // Random traffic: sticky, sparse and dense request patterns with random releases.
        do_reset();
        r = '0;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       r = 16'($urandom);
                1:       r = 16'($urandom & $urandom & $urandom);
                default: r = r;
            endcase
            rl = ($urandom_range(0, 3) == 0);
            step(r, rl);
        end

        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
